// File: rtl/pes_sdw_gen.sv
// pes_sdw_gen: serial frame generator feeding the pes_sdw sequence detector.
//
// A payload word accepted through a valid/ready handshake is sent as a
// frame of SYNC_W sync bits followed by DATA_W payload bits, MSB first, one
// bit per clock. GAP idle cycles follow each frame.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   load_valid  payload offered by the source
//   load_data   payload word (DATA_W bits)
//   load_ready  generator can accept a payload (high only in IDLE)
//   abort       synchronous frame abort, priority over everything else
//   dout        serial bit to the detector din
//   dout_en     dout carries a frame bit this cycle
//   sync_mark   high while the last sync bit is on dout
//   done        high while the last payload bit is on dout

module pes_sdw_gen #(
    parameter int              SYNC_W = 4,
    parameter logic [SYNC_W-1:0] SYNC = 4'b1011,
    parameter int              DATA_W = 8,
    parameter int              GAP    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    input  logic              abort,
    output logic              dout,
    output logic              dout_en,
    output logic              sync_mark,
    output logic              done
);

    localparam int FW   = SYNC_W + DATA_W;
    localparam int MAX1 = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int MAX2 = (MAX1 > GAP) ? MAX1 : GAP;
    localparam int MAXV = (MAX2 > 2) ? MAX2 : 2;
    localparam int CW   = $clog2(MAXV);

    typedef enum logic [1:0] {
        IDLE,
        SYNC_ST,
        DATA_ST,
        GAP_ST
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [FW-1:0]   sreg, sreg_n;
    logic            dout_n, en_n, sm_n, done_n;
    logic [FW-1:0]   frame;

    assign load_ready = (state == IDLE);
    assign frame      = {SYNC, load_data};

    // State, counter, shift register and all serial outputs are registered.
    // The shift register holds the frame bits still to be sent; its MSB is
    // the next bit to appear on dout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            sreg      <= '0;
            dout      <= 1'b0;
            dout_en   <= 1'b0;
            sync_mark <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            sreg      <= sreg_n;
            dout      <= dout_n;
            dout_en   <= en_n;
            sync_mark <= sm_n;
            done      <= done_n;
        end
    end

    // Next-state and next-output decode. cnt holds the number of bits (or
    // gap cycles) remaining in the current phase after the one now showing,
    // so it is only ever loaded with in-range values and never wraps.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sreg_n  = sreg;
        dout_n  = 1'b0;
        en_n    = 1'b0;
        sm_n    = 1'b0;
        done_n  = 1'b0;

        case (state)
            IDLE: begin
                if (load_valid && !abort) begin
                    state_n = SYNC_ST;
                    cnt_n   = CW'(SYNC_W - 1);
                    sreg_n  = frame << 1;
                    dout_n  = frame[FW-1];
                    en_n    = 1'b1;
                    sm_n    = (SYNC_W == 1);
                end
            end

            SYNC_ST: begin
                if (abort) begin
                    state_n = IDLE;
                end else begin
                    dout_n = sreg[FW-1];
                    en_n   = 1'b1;
                    sreg_n = sreg << 1;
                    if (cnt == '0) begin
                        state_n = DATA_ST;
                        cnt_n   = CW'(DATA_W - 1);
                        done_n  = (DATA_W == 1);
                    end else begin
                        cnt_n = cnt - 1'b1;
                        sm_n  = (cnt == CW'(1));
                    end
                end
            end

            DATA_ST: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (cnt == '0) begin
                    // Last payload bit is on dout now; with no gap the block
                    // goes straight back to IDLE.
                    if (GAP > 0) begin
                        state_n = GAP_ST;
                        cnt_n   = CW'(GAP - 1);
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    dout_n = sreg[FW-1];
                    en_n   = 1'b1;
                    sreg_n = sreg << 1;
                    cnt_n  = cnt - 1'b1;
                    done_n = (cnt == CW'(1));
                end
            end

            GAP_ST: begin
                if (abort || cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end

            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pes_sdw_gen.sv
// tb_pes_sdw_gen: directed bench for pes_sdw_gen.
// Instance a uses the default parameters (GAP=2); instance b uses GAP=0 for
// back-to-back framing. Expected frames are hand-written {sync, payload}
// constants.

module tb_pes_sdw_gen;

    logic       clk;
    logic       reset;

    logic       a_valid, a_abort, a_ready, a_dout, a_en, a_sm, a_done;
    logic [7:0] a_data;
    logic       b_valid, b_abort, b_ready, b_dout, b_en, b_sm, b_done;
    logic [7:0] b_data;

    int tests  = 0;
    int failed = 0;

    pes_sdw_gen #(.SYNC_W(4), .SYNC(4'b1011), .DATA_W(8), .GAP(2)) dut_a (
        .clk(clk), .reset(reset),
        .load_valid(a_valid), .load_data(a_data), .load_ready(a_ready),
        .abort(a_abort), .dout(a_dout), .dout_en(a_en),
        .sync_mark(a_sm), .done(a_done)
    );

    pes_sdw_gen #(.SYNC_W(4), .SYNC(4'b1011), .DATA_W(8), .GAP(0)) dut_b (
        .clk(clk), .reset(reset),
        .load_valid(b_valid), .load_data(b_data), .load_ready(b_ready),
        .abort(b_abort), .dout(b_dout), .dout_en(b_en),
        .sync_mark(b_sm), .done(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic [11:0] exp;
    } frame_vec_t;

    frame_vec_t vecs [4];

    task automatic checkOutput(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Packed view of one instance's outputs: {dout, en, sync_mark, done, ready}
    function automatic logic [4:0] outs(input bit sel);
        if (sel) return {b_dout, b_en, b_sm, b_done, b_ready};
        return {a_dout, a_en, a_sm, a_done, a_ready};
    endfunction

    // Offer a payload on instance a and wait (bounded) for the accepting edge.
    // Returns #1 after that edge, i.e. sampling frame cycle 1.
    task automatic applyStimulus(input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        a_valid = 1'b1;
        a_data  = d;
        while (!a_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!a_ready) checkOutput("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
    endtask

    // Check 12 frame cycles, gap cycles, then the idle cycle with ready high.
    task automatic checkFrame(input bit sel, input logic [11:0] exp,
                              input int gap, input bit holdFF);
        logic [4:0] o;
        logic [3:0] hist;
        hist = 4'b0;
        for (int i = 0; i < 12; i++) begin
            o = outs(sel);
            checkOutput("dout", int'(o[4]), int'(exp[11-i]));
            checkOutput("dout_en", int'(o[3]), 1);
            checkOutput("sync_mark", int'(o[2]), (i == 3) ? 1 : 0);
            checkOutput("done", int'(o[1]), (i == 11) ? 1 : 0);
            checkOutput("load_ready_busy", int'(o[0]), 0);
            hist = {hist[2:0], o[4]};
            if (i == 3) checkOutput("detector_y", int'(hist == 4'b1011), 1);
            if (holdFF && i == 2) begin
                a_valid = 1'b1;
                a_data  = 8'hFF;
            end
            @(posedge clk);
            #1;
        end
        for (int g = 0; g < gap; g++) begin
            o = outs(sel);
            checkOutput("gap_dout_en", int'(o[3]), 0);
            checkOutput("gap_dout", int'(o[4]), 0);
            checkOutput("gap_ready", int'(o[0]), 0);
            @(posedge clk);
            #1;
        end
        o = outs(sel);
        checkOutput("idle_ready", int'(o[0]), 1);
        checkOutput("idle_dout_en", int'(o[3]), 0);
    endtask

    initial begin
        logic [4:0] o;
        vecs[0] = '{8'hA5, 12'hBA5};
        vecs[1] = '{8'h00, 12'hB00};
        vecs[2] = '{8'h5A, 12'hB5A};
        vecs[3] = '{8'h01, 12'hB01};

        reset   = 1'b1;
        a_valid = 1'b0; a_abort = 1'b0; a_data = 8'h00;
        b_valid = 1'b0; b_abort = 1'b0; b_data = 8'h00;

        // Reset for 2 cycles, then 20 idle cycles
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checkOutput("rst_dout", int'(a_dout), 0);
            checkOutput("rst_dout_en", int'(a_en), 0);
            checkOutput("rst_ready", int'(a_ready), 1);
            checkOutput("rst_sync_mark", int'(a_sm), 0);
            checkOutput("rst_done", int'(a_done), 0);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            checkOutput("idle_dout", int'(a_dout), 0);
            checkOutput("idle_en", int'(a_en), 0);
            checkOutput("idle_rdy", int'(a_ready), 1);
        end

        // Table-driven single frames
        foreach (vecs[k]) begin
            applyStimulus(vecs[k].data);
            checkFrame(1'b0, vecs[k].exp, 2, 1'b0);
        end

        // Load while busy: FF held from cycle 3 of an A5 frame
        applyStimulus(8'hA5);
        checkFrame(1'b0, 12'hBA5, 2, 1'b1);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        checkFrame(1'b0, 12'hBFF, 2, 1'b0);

        // Abort on payload bit 3 of 3C (frame cycle 9)
        applyStimulus(8'h3C);
        for (int i = 0; i < 9; i++) begin
            checkOutput("abort_pre_dout", int'(a_dout), int'(((12'hB3C >> (11 - i)) & 12'h1) != 0));
            checkOutput("abort_pre_done", int'(a_done), 0);
            if (i == 8) a_abort = 1'b1;
            @(posedge clk);
            #1;
        end
        a_abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput("abort_dout", int'(a_dout), 0);
            checkOutput("abort_dout_en", int'(a_en), 0);
            checkOutput("abort_done", int'(a_done), 0);
            checkOutput("abort_ready", int'(a_ready), 1);
            @(posedge clk);
            #1;
        end

        // Abort in IDLE rejects a coincident load
        @(negedge clk);
        a_valid = 1'b1; a_data = 8'hC3; a_abort = 1'b1;
        @(posedge clk);
        #1;
        a_valid = 1'b0; a_abort = 1'b0;
        checkOutput("idle_abort_ready", int'(a_ready), 1);
        checkOutput("idle_abort_en", int'(a_en), 0);

        // Asynchronous reset during the third sync bit (dout=1)
        applyStimulus(8'h55);
        @(posedge clk);
        @(posedge clk);
        #3;
        checkOutput("pre_rst_dout", int'(a_dout), 1);
        reset = 1'b1;
        #1;
        checkOutput("async_rst_dout", int'(a_dout), 0);
        checkOutput("async_rst_en", int'(a_en), 0);
        checkOutput("async_rst_ready", int'(a_ready), 1);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(8'h01);
        checkFrame(1'b0, 12'hB01, 2, 1'b0);

        // GAP=0 instance: back-to-back 81 then 7E
        @(negedge clk);
        b_valid = 1'b1;
        b_data  = 8'h81;
        @(posedge clk);
        #1;
        b_data = 8'h7E;
        checkFrame(1'b1, 12'hB81, 0, 1'b0);
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        checkFrame(1'b1, 12'hB7E, 0, 1'b0);
        o = outs(1'b1);
        checkOutput("b_final_en", int'(o[3]), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Absolute time limit so the bench always reaches its summary
    initial begin
        #200000;
        failed++;
        $display("[TB] FAIL global_timeout: got 0 expected 1");
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
